pll_sequencer: RTL and testbench

PLL_SEQUENCER -- requirements
Module: pll_sequencer

---
 rtl/pll_seq_pkg.sv | 38 +++
 rtl/pll_sequencer_run_counter.sv | 46 ++++
 rtl/pll_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_pll_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared definitions for the PLL sequencer: state encodings, phase-detector
// error codes, default parameter values and the frequency-window helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_TRACK   = 3'd3,
    ST_FAULT   = 3'd4
  } pll_state_e;

  // Phase-detector codes on pll_error
  localparam logic [1:0] ERR_ALIGNED = 2'b00;
  localparam logic [1:0] ERR_LEAD    = 2'b01;
  localparam logic [1:0] ERR_LAG     = 2'b10;
  localparam logic [1:0] ERR_INVALID = 2'b11;

  // Default parameter values for pll_sequencer
  localparam logic [31:0] DEFAULT_FREQ_D = 32'h0000_9C40;
  localparam logic [31:0] FREQ_MIN_D     = 32'h0000_8000;
  localparam logic [31:0] FREQ_MAX_D     = 32'h0000_B000;
  localparam logic [4:0]  LG_ACQ_D       = 5'd12;
  localparam logic [4:0]  LG_TRACK_D     = 5'd16;
  localparam logic [15:0] LOCK_CNT_D     = 16'd64;
  localparam logic [15:0] UNLOCK_CNT_D   = 16'd8;
  localparam logic [15:0] ACQ_TIMEOUT_D  = 16'd4096;
  localparam logic [15:0] FAULT_HOLD_D   = 16'd16;

  // Inclusive window test for the PLL frequency word
  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/pll_sequencer_run_counter.sv
// run_counter
// Saturating 16-bit consecutive-event counter.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : clear to zero (wins over inc)
//   inc       : count one event this cycle
//   threshold : terminal count
//   hit       : this cycle's increment brings the count to threshold
// hit is combinational so the owning FSM can react in the same cycle the
// threshold-th event is seen; the FSM registers every externally visible
// consequence.
module run_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  input  logic [15:0] threshold,
  output logic        hit
);

  logic [15:0] count_r;
  logic [15:0] count_inc_s;

  // Saturating increment value and threshold detection
  always_comb begin
    if (count_r == 16'hFFFF) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + 16'd1;
    end
    hit = inc && (count_inc_s == threshold);
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (inc) begin
      count_r <= count_inc_s;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/pll_sequencer.sv
// pll_sequencer
// Brings a PLL from power-up to lock: preloads a default frequency word,
// acquires with a wide loop gain, tracks with a narrow one, and drops into a
// timed fault dwell on invalid detector codes, out-of-window frequency words
// or acquisition timeout.
//   clk, rst       : clock, synchronous active-high reset
//   swipt_alive    : enable; low forces IDLE from any state
//   pll_error[1:0] : detector code (00 aligned, 01 lead, 10 lag, 11 invalid)
//   pll_phase[31:0]: frequency word reported by the PLL
//   freq_out[31:0] : frequency word to the PLL / SwiptOut
//   load_freq      : PLL preload strobe
//   lgcoefficient  : loop-gain shift
//   locked, fault  : high in TRACK / FAULT respectively
//   state[2:0]     : current state encoding
// All outputs are registered and follow the next-state decision by one cycle.
module pll_sequencer
  import pll_seq_pkg::*;
#(
  parameter logic [31:0] DEFAULT_FREQ = DEFAULT_FREQ_D,
  parameter logic [31:0] FREQ_MIN     = FREQ_MIN_D,
  parameter logic [31:0] FREQ_MAX     = FREQ_MAX_D,
  parameter logic [4:0]  LG_ACQ       = LG_ACQ_D,
  parameter logic [4:0]  LG_TRACK     = LG_TRACK_D,
  parameter logic [15:0] LOCK_CNT     = LOCK_CNT_D,
  parameter logic [15:0] UNLOCK_CNT   = UNLOCK_CNT_D,
  parameter logic [15:0] ACQ_TIMEOUT  = ACQ_TIMEOUT_D,
  parameter logic [15:0] FAULT_HOLD   = FAULT_HOLD_D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        swipt_alive,
  input  logic [1:0]  pll_error,
  input  logic [31:0] pll_phase,
  output logic [31:0] freq_out,
  output logic        load_freq,
  output logic [4:0]  lgcoefficient,
  output logic        locked,
  output logic        fault,
  output logic [2:0]  state
);

  pll_state_e  state_r;
  pll_state_e  state_nxt_s;
  logic        in_window_s;
  logic        state_chg_s;
  logic        lock_hit_s;
  logic        unlock_hit_s;
  logic        tmo_hit_s;
  logic        dwell_hit_s;
  logic [31:0] freq_nxt_s;
  logic        load_nxt_s;
  logic [4:0]  lg_nxt_s;
  logic        locked_nxt_s;
  logic        fault_nxt_s;

  assign in_window_s = in_window(pll_phase, FREQ_MIN, FREQ_MAX);
  // Every counter restarts from zero whenever the FSM moves to another state.
  assign state_chg_s = (state_nxt_s != state_r);
  assign state       = state_r;

  // Consecutive aligned codes while acquiring; any other code breaks the run
  run_counter u_lock_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_chg_s || (pll_error != ERR_ALIGNED)),
    .inc       ((state_r == ST_ACQUIRE) && (pll_error == ERR_ALIGNED)),
    .threshold (LOCK_CNT),
    .hit       (lock_hit_s)
  );

  // Consecutive lead/lag codes while tracking; an aligned code breaks the run
  run_counter u_unlock_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_chg_s || (pll_error == ERR_ALIGNED)),
    .inc       ((state_r == ST_TRACK) &&
                ((pll_error == ERR_LEAD) || (pll_error == ERR_LAG))),
    .threshold (UNLOCK_CNT),
    .hit       (unlock_hit_s)
  );

  // Cycles spent in ACQUIRE
  run_counter u_tmo_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_chg_s),
    .inc       (state_r == ST_ACQUIRE),
    .threshold (ACQ_TIMEOUT),
    .hit       (tmo_hit_s)
  );

  // Cycles spent in FAULT
  run_counter u_dwell_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_chg_s),
    .inc       (state_r == ST_FAULT),
    .threshold (FAULT_HOLD),
    .hit       (dwell_hit_s)
  );

  // Next-state decision; fault causes are tested before lock/unlock so a
  // fault seen in the same cycle as a threshold always wins.
  always_comb begin
    state_nxt_s = state_r;
    if (!swipt_alive) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:    state_nxt_s = ST_LOAD;
        ST_LOAD:    state_nxt_s = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (pll_error == ERR_INVALID) begin
            state_nxt_s = ST_FAULT;
          end else if (!in_window_s) begin
            state_nxt_s = ST_FAULT;
          end else if (tmo_hit_s) begin
            state_nxt_s = ST_FAULT;
          end else if (lock_hit_s) begin
            state_nxt_s = ST_TRACK;
          end else begin
            state_nxt_s = ST_ACQUIRE;
          end
        end
        ST_TRACK: begin
          if (pll_error == ERR_INVALID) begin
            state_nxt_s = ST_FAULT;
          end else if (!in_window_s) begin
            state_nxt_s = ST_FAULT;
          end else if (unlock_hit_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_TRACK;
          end
        end
        ST_FAULT: begin
          if (dwell_hit_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_FAULT;
          end
        end
        default:    state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Output values for the state being entered. In ACQUIRE/TRACK the PLL word
  // is only followed when we were already acquiring/tracking; an out-of-window
  // word never reaches freq_out because it sends the FSM to FAULT instead.
  always_comb begin
    freq_nxt_s   = freq_out;
    load_nxt_s   = 1'b1;
    lg_nxt_s     = LG_ACQ;
    locked_nxt_s = 1'b0;
    fault_nxt_s  = 1'b0;
    case (state_nxt_s)
      ST_IDLE, ST_LOAD: freq_nxt_s = DEFAULT_FREQ;
      ST_ACQUIRE: begin
        load_nxt_s = 1'b0;
        if (state_r == ST_ACQUIRE) begin
          freq_nxt_s = pll_phase;
        end else begin
          freq_nxt_s = freq_out;
        end
      end
      ST_TRACK: begin
        load_nxt_s   = 1'b0;
        lg_nxt_s     = LG_TRACK;
        locked_nxt_s = 1'b1;
        freq_nxt_s   = pll_phase;
      end
      ST_FAULT: begin
        fault_nxt_s = 1'b1;
        freq_nxt_s  = DEFAULT_FREQ;
      end
      default: freq_nxt_s = DEFAULT_FREQ;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      freq_out      <= DEFAULT_FREQ;
      load_freq     <= 1'b1;
      lgcoefficient <= LG_ACQ;
      locked        <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      freq_out      <= freq_nxt_s;
      load_freq     <= load_nxt_s;
      lgcoefficient <= lg_nxt_s;
      locked        <= locked_nxt_s;
      fault         <= fault_nxt_s;
    end
  end

endmodule

// File: tb/tb_pll_sequencer.sv
// Directed testbench for pll_sequencer with hand-computed expectations.
module tb_pll_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        swipt_alive;
  logic [1:0]  pll_error;
  logic [31:0] pll_phase;
  logic [31:0] freq_out;
  logic        load_freq;
  logic [4:0]  lgcoefficient;
  logic        locked;
  logic        fault;
  logic [2:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pll_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .swipt_alive   (swipt_alive),
    .pll_error     (pll_error),
    .pll_phase     (pll_phase),
    .freq_out      (freq_out),
    .load_freq     (load_freq),
    .lgcoefficient (lgcoefficient),
    .locked        (locked),
    .fault         (fault),
    .state         (state)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset, release, one LOAD cycle, land in the first ACQUIRE cycle
  task automatic goto_acquire();
    rst = 1'b1; swipt_alive = 1'b1; pll_error = 2'b00; pll_phase = 32'h0000_9D00;
    tick(1);
    rst = 1'b0;
    tick(1);
    n_checks++;
    if (state !== 3'd1 || load_freq !== 1'b1) begin
      n_fail++; $display("FAIL enter_load: state=%0d load=%0b want 1/1", state, load_freq);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd2 || load_freq !== 1'b0 || lgcoefficient !== 5'd12) begin
      n_fail++; $display("FAIL enter_acq: state=%0d load=%0b lg=%0d want 2/0/12", state, load_freq, lgcoefficient);
    end
  endtask

  task automatic goto_track();
    goto_acquire();
    tick(64);
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL enter_track: state=%0d want 3", state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; swipt_alive = 1'b0; pll_error = 2'b00; pll_phase = 32'h0000_9D00;
    tick(2);
    n_checks++;
    if (state !== 3'd0 || freq_out !== 32'h0000_9C40 || load_freq !== 1'b1 ||
        lgcoefficient !== 5'd12 || locked !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL reset_values: state=%0d freq=%h load=%0b lg=%0d lock=%0b fault=%0b want 0/9c40/1/12/0/0",
                         state, freq_out, load_freq, lgcoefficient, locked, fault);
    end
    rst = 1'b0;
    tick(3);
    n_checks++;
    if (state !== 3'd0) begin
      n_fail++; $display("FAIL idle_without_alive: state=%0d want 0", state);
    end
  endtask

  task automatic test_lock_basic();
    int n;
    goto_acquire();
    n = 1;
    while (state == 3'd2 && n < 200) begin
      tick(1);
      if (state == 3'd2) n++;
    end
    n_checks++;
    if (n !== 64) begin
      n_fail++; $display("FAIL acq_cycles: got %0d want 64", n);
    end
    n_checks++;
    if (state !== 3'd3 || locked !== 1'b1 || lgcoefficient !== 5'd16 ||
        freq_out !== 32'h0000_9D00 || load_freq !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL track_values: state=%0d lock=%0b lg=%0d freq=%h load=%0b fault=%0b want 3/1/16/9d00/0/0",
                         state, locked, lgcoefficient, freq_out, load_freq, fault);
    end
  endtask

  task automatic test_lock_restart();
    goto_acquire();
    tick(63);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL restart_first_run: state=%0d want 2", state);
    end
    pll_error = 2'b01;
    tick(1);
    pll_error = 2'b00;
    tick(63);
    n_checks++;
    if (state !== 3'd2 || locked !== 1'b0) begin
      n_fail++; $display("FAIL restart_63: state=%0d lock=%0b want 2/0", state, locked);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd3 || locked !== 1'b1) begin
      n_fail++; $display("FAIL restart_64: state=%0d lock=%0b want 3/1", state, locked);
    end
  endtask

  task automatic test_unlock();
    pll_error = 2'b10;
    tick(7);
    n_checks++;
    if (state !== 3'd3 || locked !== 1'b1) begin
      n_fail++; $display("FAIL unlock_run1: state=%0d lock=%0b want 3/1", state, locked);
    end
    pll_error = 2'b00;
    tick(1);
    pll_error = 2'b10;
    tick(7);
    n_checks++;
    if (state !== 3'd3 || locked !== 1'b1) begin
      n_fail++; $display("FAIL unlock_7lag: state=%0d lock=%0b want 3/1", state, locked);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd1 || locked !== 1'b0 || load_freq !== 1'b1 || freq_out !== 32'h0000_9C40) begin
      n_fail++; $display("FAIL unlock_8lag: state=%0d lock=%0b load=%0b freq=%h want 1/0/1/9c40",
                         state, locked, load_freq, freq_out);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL reacquire: state=%0d want 2", state);
    end
  endtask

  task automatic test_window();
    goto_track();
    pll_phase = 32'h0000_B000;
    tick(1);
    n_checks++;
    if (state !== 3'd3 || freq_out !== 32'h0000_B000) begin
      n_fail++; $display("FAIL window_max: state=%0d freq=%h want 3/b000", state, freq_out);
    end
    pll_phase = 32'h0000_8000;
    tick(1);
    n_checks++;
    if (state !== 3'd3 || freq_out !== 32'h0000_8000) begin
      n_fail++; $display("FAIL window_min: state=%0d freq=%h want 3/8000", state, freq_out);
    end
    pll_phase = 32'h0000_C000;
    tick(1);
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1 || freq_out !== 32'h0000_9C40 ||
        load_freq !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL window_fault: state=%0d fault=%0b freq=%h load=%0b lock=%0b want 4/1/9c40/1/0",
                         state, fault, freq_out, load_freq, locked);
    end
    pll_phase = 32'h0000_9D00;
    tick(15);
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      n_fail++; $display("FAIL dwell_15: state=%0d fault=%0b want 4/1", state, fault);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL dwell_16: state=%0d fault=%0b want 0/0", state, fault);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd1) begin
      n_fail++; $display("FAIL idle_to_load: state=%0d want 1", state);
    end
    goto_acquire();
    pll_phase = 32'h0000_7FFF;
    tick(1);
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      n_fail++; $display("FAIL window_below: state=%0d fault=%0b want 4/1", state, fault);
    end
  endtask

  task automatic test_invalid();
    goto_track();
    pll_error = 2'b11;
    tick(1);
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL invalid_code: state=%0d fault=%0b lock=%0b want 4/1/0", state, fault, locked);
    end
  endtask

  task automatic test_timeout();
    goto_acquire();
    pll_error = 2'b01;
    tick(4095);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL timeout_4095: state=%0d want 2", state);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd4 || fault !== 1'b1) begin
      n_fail++; $display("FAIL timeout_4096: state=%0d fault=%0b want 4/1", state, fault);
    end
    swipt_alive = 1'b0;
    tick(1);
    n_checks++;
    if (state !== 3'd0 || fault !== 1'b0 || freq_out !== 32'h0000_9C40) begin
      n_fail++; $display("FAIL fault_abort: state=%0d fault=%0b freq=%h want 0/0/9c40", state, fault, freq_out);
    end
  endtask

  task automatic test_alive_drop();
    goto_acquire();
    tick(5);
    swipt_alive = 1'b0;
    tick(1);
    n_checks++;
    if (state !== 3'd0 || load_freq !== 1'b1 || lgcoefficient !== 5'd12) begin
      n_fail++; $display("FAIL alive_drop: state=%0d load=%0b lg=%0d want 0/1/12", state, load_freq, lgcoefficient);
    end
  endtask

  task automatic test_rst_mid_track();
    goto_track();
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (state !== 3'd0 || freq_out !== 32'h0000_9C40 || load_freq !== 1'b1 ||
        lgcoefficient !== 5'd12 || locked !== 1'b0 || fault !== 1'b0) begin
      n_fail++; $display("FAIL rst_track: state=%0d freq=%h load=%0b lg=%0d lock=%0b fault=%0b want 0/9c40/1/12/0/0",
                         state, freq_out, load_freq, lgcoefficient, locked, fault);
    end
    rst = 1'b0;
    tick(2);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL rst_reacq: state=%0d want 2", state);
    end
    tick(63);
    n_checks++;
    if (state !== 3'd2) begin
      n_fail++; $display("FAIL rst_no_residual: state=%0d want 2", state);
    end
    tick(1);
    n_checks++;
    if (state !== 3'd3) begin
      n_fail++; $display("FAIL rst_relock: state=%0d want 3", state);
    end
  endtask

  initial begin
    test_reset();
    test_lock_basic();
    test_lock_restart();
    test_unlock();
    test_window();
    test_invalid();
    test_timeout();
    test_alive_drop();
    test_rst_mid_track();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
